// File: rtl/burst_master_pkg.sv
// Shared state encoding and default sizing for the serial burst master.
package burst_master_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 3;
  localparam int DEF_ACK_TO = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ACK_A,
    WDATA,
    ACK_W,
    RDATA,
    HOLD
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/burst_master_if.sv
// Host-side request/data signals and serial bus signals of the burst master.
interface burst_master_if
  import burst_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
);
  logic              m_execute;
  logic              m_rw;
  logic [ADDR_W-1:0] m_addr;
  logic [LEN_W-1:0]  m_len;
  logic [DATA_W-1:0] m_din;
  logic [DATA_W-1:0] m_dout;
  logic              m_dvalid;
  logic              m_dreq;
  logic              m_bsy;
  logic              m_err;
  logic              b_req;
  logic              b_grant;
  logic              b_ready;
  logic              b_util;
  logic              b_rw;
  logic              b_ack;
  logic              b_done;
  logic              a_add;
  logic              b_bus_out;
  logic              b_bus_in;

  modport master (
    input  m_execute, m_rw, m_addr, m_len, m_din, b_grant, b_ready, b_ack, b_bus_in,
    output m_dout, m_dvalid, m_dreq, m_bsy, m_err, b_req, b_util, b_rw, b_done,
           a_add, b_bus_out
  );

  modport slave (
    output m_execute, m_rw, m_addr, m_len, m_din, b_grant, b_ready, b_ack, b_bus_in,
    input  m_dout, m_dvalid, m_dreq, m_bsy, m_err, b_req, b_util, b_rw, b_done,
           a_add, b_bus_out
  );

endinterface

// File: rtl/burst_master_counter.sv
// Up-counter with synchronous clear; used for bit, word and ack-timeout counts.
module burst_master_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/burst_master.sv
// Serial burst master: LSB-first address phase, then write or read data words.
// Define BURST_MASTER_BURST_EN to honour m_len; otherwise every transaction is one word.
module burst_master
  import burst_master_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int ACK_TO = DEF_ACK_TO
) (
  input logic            clk,
  input logic            rst_n,
  burst_master_if.master bus
);

  localparam int BIT_W = $clog2(max_int(ADDR_W, DATA_W));
  localparam int TO_W  = $clog2(ACK_TO + 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              rw_q, rw_d;
  logic              dvalid_q, dvalid_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
`ifdef BURST_MASTER_BURST_EN
  logic [LEN_W-1:0]  len_q, len_d;
  logic              dreq_q, dreq_d;
`endif

  logic              bit_clr, bit_inc, word_clr, word_inc, to_clr, to_inc;
  logic [BIT_W-1:0]  bit_cnt;
  logic [LEN_W-1:0]  word_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              last_word, ack_expired;
  logic              b_req, b_util, bus_out, a_add;

  burst_master_counter #(.W(BIT_W)) u_bit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(bit_clr), .inc(bit_inc), .cnt(bit_cnt));
  burst_master_counter #(.W(LEN_W)) u_word_cnt (
    .clk(clk), .rst_n(rst_n), .clr(word_clr), .inc(word_inc), .cnt(word_cnt));
  burst_master_counter #(.W(TO_W)) u_to_cnt (
    .clk(clk), .rst_n(rst_n), .clr(to_clr), .inc(to_inc), .cnt(to_cnt));

`ifdef BURST_MASTER_BURST_EN
  assign last_word = (word_cnt == len_q);
`else
  assign last_word = (word_cnt == '0);
`endif
  assign ack_expired = (to_cnt == TO_W'(ACK_TO - 1));

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    din_d    = din_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    rw_d     = rw_q;
    dvalid_d = 1'b0;
    err_d    = 1'b0;
    done_d   = 1'b0;
`ifdef BURST_MASTER_BURST_EN
    len_d    = len_q;
    dreq_d   = 1'b0;
`endif
    bit_clr  = 1'b0;
    bit_inc  = 1'b0;
    word_clr = 1'b0;
    word_inc = 1'b0;
    to_clr   = 1'b1;
    to_inc   = 1'b0;
    b_req    = 1'b1;
    b_util   = 1'b0;
    bus_out  = 1'b0;
    a_add    = 1'b0;

    unique case (state_q)
      IDLE: begin
        b_req = bus.m_execute;
        if (bus.m_execute && bus.b_grant) begin
          addr_d  = bus.m_addr;
          din_d   = bus.m_din;
          rw_d    = bus.m_rw;
`ifdef BURST_MASTER_BURST_EN
          len_d   = bus.m_len;
`endif
          bit_clr = 1'b1;
          state_d = ADDR;
        end
      end

      // Address shifts out of the LSB; the first two slave-select bits never wait for b_ready.
      ADDR: begin
        b_util  = 1'b1;
        bus_out = addr_q[0];
        a_add   = (bit_cnt < BIT_W'(2));
        if (!bus.b_grant) begin
          bit_clr = 1'b1;
          state_d = IDLE;
        end else if (a_add || bus.b_ready) begin
          addr_d = addr_q >> 1;
          if (bit_cnt == BIT_W'(ADDR_W - 1)) begin
            bit_clr = 1'b1;
            state_d = ACK_A;
          end else begin
            bit_inc = 1'b1;
          end
        end
      end

      ACK_A, ACK_W: begin
        b_util = 1'b1;
        if (bus.b_ack) begin
          bit_clr = 1'b1;
          if (state_q == ACK_A) begin
            word_clr = 1'b1;
            state_d  = rw_q ? WDATA : RDATA;
          end else if (!last_word) begin
`ifdef BURST_MASTER_BURST_EN
            dreq_d = 1'b1;
`endif
            din_d    = bus.m_din;
            word_inc = 1'b1;
            state_d  = WDATA;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else if (ack_expired) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          to_clr = 1'b0;
          to_inc = 1'b1;
        end
      end

      WDATA: begin
        b_util  = 1'b1;
        bus_out = din_q[0];
        din_d   = din_q >> 1;
        if (bit_cnt == BIT_W'(DATA_W - 1)) begin
          bit_clr = 1'b1;
          state_d = ACK_W;
        end else begin
          bit_inc = 1'b1;
        end
      end

      // Read bits enter at the MSB so the word is LSB-aligned after DATA_W samples.
      RDATA: begin
        b_util = 1'b1;
        if (!bus.b_grant) begin
          state_d = HOLD;
        end else begin
          shift_d = {bus.b_bus_in, shift_q[DATA_W-1:1]};
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            dout_d   = shift_d;
            dvalid_d = 1'b1;
            bit_clr  = 1'b1;
            if (last_word) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              word_inc = 1'b1;
            end
          end else begin
            bit_inc = 1'b1;
          end
        end
      end

      HOLD: begin
        if (bus.b_grant) state_d = RDATA;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      din_q    <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      rw_q     <= 1'b0;
      dvalid_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      rw_q     <= rw_d;
      dvalid_q <= dvalid_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

`ifdef BURST_MASTER_BURST_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      dreq_q <= 1'b0;
    end else begin
      len_q  <= len_d;
      dreq_q <= dreq_d;
    end
  end
  assign bus.m_dreq = dreq_q;
`else
  assign bus.m_dreq = 1'b0;
`endif

  assign bus.m_dout    = dout_q;
  assign bus.m_dvalid  = dvalid_q;
  assign bus.m_bsy     = (state_q != IDLE);
  assign bus.m_err     = err_q;
  assign bus.b_req     = b_req;
  assign bus.b_util    = b_util;
  assign bus.b_rw      = rw_q & (state_q != IDLE);
  assign bus.b_done    = done_q;
  assign bus.a_add     = a_add;
  assign bus.b_bus_out = bus_out;

endmodule

// File: tb/tb_burst_master.sv
// Bench for burst_master: builds a per-cycle schedule of stimulus and expected outputs
// from transaction-level rules, then replays it against the DUT.
module tb_burst_master;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 3;
  localparam int ACK_TO = 3;
`ifdef BURST_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef struct {
    logic              rst, exec, rw, grant, ready, ack, bus_in;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [DATA_W-1:0] din;
    logic              e_bsy, e_util, e_req, e_rw, e_out, e_aadd;
    logic              e_done, e_err, e_dvalid, e_dreq;
    logic [DATA_W-1:0] e_dout;
  } cyc_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .ACK_TO(ACK_TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  cyc_t              sched[$];
  int                errors = 0;
  int                checks = 0;
  int                cyc_idx = 0;
  bit                p_done, p_err, p_dvalid, p_dreq;
  logic [DATA_W-1:0] dout_model = '0;
  logic [DATA_W-1:0] t_words[8];
  logic [DATA_W-1:0] t_rdata[8];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: observed %0h, expected %0h", tag, cyc_idx, obs, exp);
    end
  endtask

  task automatic applyStimulus(input cyc_t c);
    rst_n         = ~c.rst;
    bus.m_execute = c.exec;
    bus.m_rw      = c.rw;
    bus.m_addr    = c.addr;
    bus.m_len     = c.len;
    bus.m_din     = c.din;
    bus.b_grant   = c.grant;
    bus.b_ready   = c.ready;
    bus.b_ack     = c.ack;
    bus.b_bus_in  = c.bus_in;
  endtask

  task automatic compare_cycle(input cyc_t c);
    checkOutput("m_bsy",     32'(bus.m_bsy),     32'(c.e_bsy));
    checkOutput("b_util",    32'(bus.b_util),    32'(c.e_util));
    checkOutput("b_req",     32'(bus.b_req),     32'(c.e_req));
    checkOutput("b_rw",      32'(bus.b_rw),      32'(c.e_rw));
    checkOutput("b_bus_out", 32'(bus.b_bus_out), 32'(c.e_out));
    checkOutput("a_add",     32'(bus.a_add),     32'(c.e_aadd));
    checkOutput("b_done",    32'(bus.b_done),    32'(c.e_done));
    checkOutput("m_err",     32'(bus.m_err),     32'(c.e_err));
    checkOutput("m_dvalid",  32'(bus.m_dvalid),  32'(c.e_dvalid));
    checkOutput("m_dreq",    32'(bus.m_dreq),    32'(c.e_dreq));
    checkOutput("m_dout",    32'(bus.m_dout),    32'(c.e_dout));
  endtask

  // Idle cycle with random don't-care inputs and all outputs expected low.
  function automatic cyc_t idle_cyc();
    cyc_t c = '{default: '0};
    c.grant  = 1'($urandom_range(0, 1));
    c.ready  = 1'($urandom_range(0, 1));
    c.rw     = 1'($urandom_range(0, 1));
    c.addr   = ADDR_W'($urandom);
    c.len    = LEN_W'($urandom);
    c.din    = DATA_W'($urandom);
    c.bus_in = 1'($urandom_range(0, 1));
    return c;
  endfunction

  // Busy cycle: host inputs are garbage (must be ignored), grant held, ack low.
  function automatic cyc_t busy_cyc(input bit rw);
    cyc_t c = idle_cyc();
    c.exec   = 1'($urandom_range(0, 1));
    c.grant  = 1'b1;
    c.e_bsy  = 1'b1;
    c.e_util = 1'b1;
    c.e_req  = 1'b1;
    c.e_rw   = rw;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    c.e_done   = p_done;
    c.e_err    = p_err;
    c.e_dvalid = p_dvalid;
    c.e_dreq   = p_dreq;
    c.e_dout   = dout_model;
    p_done = 0; p_err = 0; p_dvalid = 0; p_dreq = 0;
    sched.push_back(c);
  endtask

  task automatic ack_wait(input bit rw, input int d, output bit expired);
    for (int k = 0; k < d && k < ACK_TO; k++) push(busy_cyc(rw));
    expired = (d >= ACK_TO);
    if (expired) begin
      p_err  = 1;
      p_done = 1;
    end
  endtask

  task automatic gen_txn(input bit rw, input logic [ADDR_W-1:0] addr, input int len,
                         input int abort_bit, input int stall_bit, input int stall_len,
                         input bit rand_stall, input int a_dly, input int w_dly,
                         input int hold_bit, input int hold_len);
    cyc_t c;
    bit   expired;
    int   n, d;
    int   len_eff = BURST ? len : 0;
    if ($urandom_range(0, 2) == 0) begin
      c = idle_cyc(); c.exec = 1; c.grant = 0; c.e_req = 1; push(c);
    end
    c = idle_cyc();
    c.exec = 1; c.grant = 1; c.rw = rw; c.addr = addr; c.len = LEN_W'(len);
    c.din = t_words[0]; c.e_req = 1;
    push(c);
    for (int b = 0; b < ADDR_W; b++) begin
      if (b == abort_bit) begin
        c = busy_cyc(rw); c.e_out = addr[b]; c.e_aadd = (b < 2); c.grant = 0; push(c);
        return;
      end
      if (b >= 2) begin
        n = (b == stall_bit) ? stall_len :
            (rand_stall && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
        for (int k = 0; k < n; k++) begin
          c = busy_cyc(rw); c.e_out = addr[b]; c.ready = 0; push(c);
        end
      end
      c = busy_cyc(rw); c.e_out = addr[b]; c.e_aadd = (b < 2);
      if (b >= 2) c.ready = 1;
      push(c);
    end
    ack_wait(rw, a_dly, expired);
    if (expired) return;
    c = busy_cyc(rw); c.ack = 1; push(c);
    for (int w = 0; w <= len_eff; w++) begin
      if (rw) begin
        for (int i = 0; i < DATA_W; i++) begin
          c = busy_cyc(rw); c.e_out = t_words[w][i]; push(c);
        end
        d = (w_dly < 0) ? int'($urandom_range(0, ACK_TO - 1)) : w_dly;
        ack_wait(rw, d, expired);
        if (expired) return;
        c = busy_cyc(rw); c.ack = 1;
        if (w < len_eff) begin
          c.din = t_words[w + 1]; push(c); p_dreq = 1;
        end else begin
          push(c); p_done = 1;
        end
      end else begin
        for (int i = 0; i < DATA_W; i++) begin
          if (w == 0 && i == hold_bit) begin
            c = busy_cyc(rw); c.grant = 0; push(c);
            for (int k = 0; k < hold_len - 1; k++) begin
              c = busy_cyc(rw); c.grant = 0; c.e_util = 0; push(c);
            end
            c = busy_cyc(rw); c.e_util = 0; push(c);
          end
          c = busy_cyc(rw); c.bus_in = t_rdata[w][i]; push(c);
        end
        dout_model = t_rdata[w];
        p_dvalid   = 1;
        if (w == len_eff) p_done = 1;
      end
    end
  endtask

  task automatic gap();
    int n = int'($urandom_range(1, 3));
    for (int k = 0; k < n; k++) push(idle_cyc());
  endtask

  task automatic reset_cycles(input int n);
    cyc_t c;
    p_done = 0; p_err = 0; p_dvalid = 0; p_dreq = 0;
    dout_model = '0;
    for (int k = 0; k < n; k++) begin
      c = idle_cyc(); c.rst = 1; push(c);
    end
  endtask

  task automatic fill_words();
    for (int i = 0; i < 8; i++) begin
      t_words[i] = DATA_W'($urandom);
      t_rdata[i] = DATA_W'($urandom);
    end
  endtask

  initial begin
    int keep;
    bit rw;
    applyStimulus('{default: '0});
    rst_n = 1'b0;

    reset_cycles(2);
    gap();

    fill_words(); t_words[0] = 8'hA5;
    gen_txn(1, 16'h1234, 0, -1, -1, 0, 0, 1, 1, -1, 1); gap();

    fill_words(); t_rdata[0] = 8'h11; t_rdata[1] = 8'h22; t_rdata[2] = 8'h33;
    gen_txn(0, ADDR_W'($urandom), 2, -1, -1, 0, 0, 0, 0, -1, 1); gap();

    fill_words();
    gen_txn(0, ADDR_W'($urandom), 0, -1, -1, 0, 0, ACK_TO, 0, -1, 1); gap();

    fill_words(); t_rdata[0] = 8'h5C;
    gen_txn(0, ADDR_W'($urandom), 0, -1, -1, 0, 0, 0, 0, 4, 5); gap();

    fill_words();
    gen_txn(1, 16'hFFDF, 0, -1, 5, 4, 0, 0, 0, -1, 1); gap();

    fill_words();
    gen_txn(1, ADDR_W'($urandom), 1, 7, -1, 0, 0, 0, 0, -1, 1); gap();

    fill_words();
    gen_txn(1, ADDR_W'($urandom), 0, -1, -1, 0, 0, 0, ACK_TO, -1, 1); gap();

    fill_words();
    keep = sched.size();
    gen_txn(1, ADDR_W'($urandom), 3, -1, -1, 0, 0, 0, 0, -1, 1);
    while (sched.size() > keep + 25) void'(sched.pop_back());
    reset_cycles(2); gap();
    fill_words();
    gen_txn(1, ADDR_W'($urandom), 1, -1, -1, 0, 1, 1, -1, -1, 1); gap();

    for (int t = 0; t < 40; t++) begin
      fill_words();
      rw = 1'($urandom_range(0, 1));
      gen_txn(rw, ADDR_W'($urandom), int'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, ADDR_W - 1)) : -1,
              -1, 0, 1,
              ($urandom_range(0, 7) == 0) ? ACK_TO : int'($urandom_range(0, ACK_TO - 1)),
              ($urandom_range(0, 9) == 0) ? ACK_TO : -1,
              (!rw && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, DATA_W - 1)) : -1,
              int'($urandom_range(1, 4)));
      gap();
    end

    for (int i = 0; i < sched.size(); i++) begin
      @(negedge clk);
      applyStimulus(sched[i]);
      #1;
      cyc_idx = i;
      compare_cycle(sched[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/burst_master.md
BURST_MASTER -- requirements
Module: burst_master

Interface
REQ-001 Parameter ADDR_W, default 16, address bits shifted per transaction.
REQ-002 Parameter DATA_W, default 8, data bits per word.
REQ-003 Parameter LEN_W, default 3, width of M_LEN; burst holds M_LEN+1 words.
REQ-004 Parameter ACK_TO, default 3, cycles allowed for B_ACK after each address or write phase.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 RSTN  in  1  reset, asynchronous, active-low.
REQ-007 M_EXECUTE  in  1  start request, sampled in IDLE.
REQ-008 M_RW  in  1  1 = write, 0 = read.
REQ-009 M_ADDR  in  ADDR_W  target address.
REQ-010 M_LEN  in  LEN_W  burst length minus one.
REQ-011 M_DIN  in  DATA_W  write word.
REQ-012 M_DOUT  out  DATA_W  last read word.
REQ-013 M_DVALID  out  1  one-cycle pulse: M_DOUT updated.
REQ-014 M_DREQ  out  1  one-cycle pulse: M_DIN consumed, next word wanted.
REQ-015 M_BSY  out  1  high whenever state is not IDLE.
REQ-016 M_ERR  out  1  one-cycle pulse on ACK timeout.
REQ-017 B_REQ  out  1  bus request; B_GRANT  in  1  grant; B_READY  in  1  slave ready.
REQ-018 B_UTIL  out  1  bus in use; B_RW  out  1  latched direction; B_ACK  in  1  slave ack; B_DONE  out  1  one-cycle end pulse.
REQ-019 A_ADD  out  1  slave-select phase flag; B_BUS_OUT  out  1  serial out; B_BUS_IN  in  1  serial in.

Function
REQ-020 States SHALL be IDLE, ADDR, ACK_A, WDATA, ACK_W, RDATA, HOLD.
REQ-021 B_REQ SHALL be combinational: M_EXECUTE in IDLE, otherwise high in every non-IDLE state.
REQ-022 IDLE, M_EXECUTE & B_GRANT: latch M_ADDR, M_RW, M_LEN, M_DIN; enter ADDR next cycle, bit index 0.
REQ-023 ADDR: B_BUS_OUT = address bit[index], LSB first; index advances every cycle for bits 0-1, thereafter only when B_READY; A_ADD high while index < 2.
REQ-024 ADDR, after bit ADDR_W-1 is driven: enter ACK_A; B_GRANT low at any point in ADDR: return to IDLE, index cleared, no M_ERR.
REQ-025 ACK_A/ACK_W: B_ACK within ACK_TO cycles proceeds; no ack by cycle ACK_TO: M_ERR and B_DONE pulse, enter IDLE.
REQ-026 ACK_A + ack: WDATA if latched RW = 1, else RDATA; word counter cleared.
REQ-027 WDATA: DATA_W cycles, B_BUS_OUT = word bit[i] LSB first; then ACK_W.
REQ-028 ACK_W + ack: if words sent < M_LEN+1, pulse M_DREQ, latch M_DIN same edge, re-enter WDATA; else pulse B_DONE, enter IDLE.
REQ-029 RDATA: sample B_BUS_IN into bit[i] each granted cycle; after bit DATA_W-1, update M_DOUT and pulse M_DVALID next cycle; more words: stay in RDATA; last word: pulse B_DONE, enter IDLE.
REQ-030 RDATA, B_GRANT low: enter HOLD, bit index frozen; HOLD with B_GRANT high: resume RDATA at the frozen index.
REQ-031 B_UTIL SHALL be high in ADDR, ACK_A, WDATA, ACK_W, RDATA; low in IDLE, HOLD.
REQ-032 B_BUS_OUT SHALL be 0 outside ADDR/WDATA; M_EXECUTE outside IDLE is ignored.
REQ-033 B_RW SHALL equal latched M_RW while M_BSY, 0 in IDLE.

Reset
REQ-034 RSTN low: state IDLE, counters 0, M_DOUT 0, every 1-bit output 0, latched registers 0, effective immediately, including mid-burst.

Configuration
REQ-035 Macro BURST_MASTER_BURST_EN defined: M_LEN honoured; undefined: M_LEN ignored, every transaction one word, M_DREQ tied 0.

Structure
REQ-036 Package burst_master_pkg SHALL hold the state enum and default parameter constants.
REQ-037 Bit, word, and timeout counts SHALL use the existing parametric counter sub-module (instance per count).

Verification
REQ-038 Write ADDR 0x1234, DIN 0xA5, LEN 0, B_READY 1, ack 1 cycle after each phase -> B_BUS_OUT 16 address then 8 data bits LSB first, B_DONE one pulse, M_ERR 0.
REQ-039 Read LEN 2, slave returns 0x11, 0x22, 0x33 -> three M_DVALID pulses with M_DOUT 0x11, 0x22, 0x33; B_DONE after the third.
REQ-040 No B_ACK after address, ACK_TO 3 -> M_ERR and B_DONE pulse 3 cycles after ACK_A entry, back to IDLE.
REQ-041 Read, B_GRANT dropped after bit 3 for 5 cycles -> HOLD, B_UTIL 0, resumes at bit 4, word intact.
REQ-042 B_READY low for 4 cycles at address bit 5 -> bit 5 held on B_BUS_OUT 4 extra cycles; A_ADD high only for bits 0-1.
REQ-043 RSTN asserted mid-write burst -> all outputs 0 same cycle; new transaction after release completes normally.
